// File: rtl/fft_r2_sched.sv
// fft_r2_sched: issue/drain sequencer for an in-place radix-2 FFT butterfly.
// Every output is a flop; the write-back strobe and addresses trail ISSUE by PIPE_LAT cycles.
module fft_r2_sched #(
    parameter int LOG2N    = 3,
    parameter int PIPE_LAT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ISSUE,
    output logic [LOG2N-1:0] ADDR_A,
    output logic [LOG2N-1:0] ADDR_B,
    output logic [LOG2N-2:0] TW_IDX,
    output logic [3:0]       STAGE,
    output logic             WR_EN,
    output logic [LOG2N-1:0] WR_ADDR_A,
    output logic [LOG2N-1:0] WR_ADDR_B
);
    localparam int DW = $clog2(PIPE_LAT + 1);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;
    state_t state, state_nx;
    logic [3:0] stage, stage_nx, hb;
    logic [LOG2N-2:0] j, j_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic [LOG2N-1:0] jx, mask, a_nx;
    logic [PIPE_LAT-1:0] wv;
    logic [LOG2N-1:0] wa [PIPE_LAT];
    logic [LOG2N-1:0] wb [PIPE_LAT];

    always_comb begin
        state_nx = state;
        stage_nx = stage;
        j_nx     = j;
        dcnt_nx  = dcnt;
        case (state)
            S_IDLE:
                if (START) begin
                    state_nx = S_ISSUE;
                    stage_nx = '0;
                    j_nx     = '0;
                end
            S_ISSUE:
                if (&j) begin
                    state_nx = S_DRAIN;
                    dcnt_nx  = '0;
                    j_nx     = '0;
                end else j_nx = j + 1'b1;
            S_DRAIN:
                if (dcnt == DW'(PIPE_LAT - 1)) begin
                    state_nx = (stage == 4'(LOG2N - 1)) ? S_FIN : S_ISSUE;
                    stage_nx = (stage == 4'(LOG2N - 1)) ? stage : stage + 1'b1;
                end else dcnt_nx = dcnt + 1'b1;
            default: state_nx = S_IDLE;
        endcase
        // upper-leg address is j with a zero inserted at bit hb; span = 1 << hb
        hb   = 4'(LOG2N - 1) - stage_nx;
        jx   = LOG2N'(j_nx);
        mask = (LOG2N'(1) << hb) - 1'b1;
        a_nx = ((jx >> hb) << (hb + 1'b1)) | (jx & mask);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            stage  <= '0;
            j      <= '0;
            dcnt   <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ISSUE  <= 1'b0;
            ADDR_A <= '0;
            ADDR_B <= '0;
            TW_IDX <= '0;
            STAGE  <= '0;
        end else begin
            state <= state_nx;
            stage <= stage_nx;
            j     <= j_nx;
            dcnt  <= dcnt_nx;
            BUSY  <= state_nx != S_IDLE;
            DONE  <= state_nx == S_FIN;
            ISSUE <= state_nx == S_ISSUE;
            if (state_nx == S_ISSUE) begin
                ADDR_A <= a_nx;
                ADDR_B <= a_nx | (mask + 1'b1);
                TW_IDX <= (LOG2N-1)'((jx & mask) << stage_nx);
                STAGE  <= stage_nx;
            end
        end
    end

    // free-running delay line; clearing it on reset drops in-flight write-backs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wv <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                wa[i] <= '0;
                wb[i] <= '0;
            end
        end else begin
            wv[0] <= ISSUE;
            wa[0] <= ADDR_A;
            wb[0] <= ADDR_B;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wv[i] <= wv[i-1];
                wa[i] <= wa[i-1];
                wb[i] <= wb[i-1];
            end
        end
    end

    assign WR_EN     = wv[PIPE_LAT-1];
    assign WR_ADDR_A = wa[PIPE_LAT-1];
    assign WR_ADDR_B = wb[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_r2_sched.sv
// tb_fft_r2_sched: scoreboard bench running the default config and LOG2N=4/PIPE_LAT=1 side by side.
module tb_fft_r2_sched;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [1:0] start = '0;
    int cyc = 0;
    int n_cmp = 0, n_bad = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic bsy0, dn0, is0, we0;
    logic [2:0] a0, b0, wa0, wb0;
    logic [1:0] tw0;
    logic [3:0] st0;
    logic bsy1, dn1, is1, we1;
    logic [3:0] a1, b1, wa1, wb1;
    logic [2:0] tw1;
    logic [3:0] st1;

    fft_r2_sched #(.LOG2N(3), .PIPE_LAT(4)) u0 (
        .CLK(CLK), .RST(RST), .START(start[0]), .BUSY(bsy0), .DONE(dn0), .ISSUE(is0),
        .ADDR_A(a0), .ADDR_B(b0), .TW_IDX(tw0), .STAGE(st0),
        .WR_EN(we0), .WR_ADDR_A(wa0), .WR_ADDR_B(wb0)
    );
    fft_r2_sched #(.LOG2N(4), .PIPE_LAT(1)) u1 (
        .CLK(CLK), .RST(RST), .START(start[1]), .BUSY(bsy1), .DONE(dn1), .ISSUE(is1),
        .ADDR_A(a1), .ADDR_B(b1), .TW_IDX(tw1), .STAGE(st1),
        .WR_EN(we1), .WR_ADDR_A(wa1), .WR_ADDR_B(wb1)
    );

    int iss[2], wen[2], dn[2], bsy[2], a[2], b[2], tw[2], st[2], wa[2], wb[2];
    always_comb begin
        iss[0] = int'(is0); wen[0] = int'(we0); dn[0] = int'(dn0); bsy[0] = int'(bsy0);
        a[0] = int'(a0); b[0] = int'(b0); tw[0] = int'(tw0); st[0] = int'(st0);
        wa[0] = int'(wa0); wb[0] = int'(wb0);
        iss[1] = int'(is1); wen[1] = int'(we1); dn[1] = int'(dn1); bsy[1] = int'(bsy1);
        a[1] = int'(a1); b[1] = int'(b1); tw[1] = int'(tw1); st[1] = int'(st1);
        wa[1] = int'(wa1); wb[1] = int'(wb1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic string tg(input int k, input string nm);
        return $sformatf("cfg%0d %s cycle %0d", k, nm, cyc);
    endfunction

    // per-config ring-buffer queues: issue expectations and pending write-backs
    int t0[2] = '{-1, -1};
    int qa[2][64], qb[2][64], qt[2][64], qs[2][64], wqa[2][64], wqb[2][64];
    int ih[2], it[2], wh[2], wt[2];
    int la[2], lb[2], lt[2], ls[2];

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            int lg, pl, n, l, t, rel, x, span, ei, ew, ed, eb;
            lg = k ? 4 : 3;
            pl = k ? 1 : 4;
            n = 1 << lg;
            l = n / 2 + pl;
            t = lg * l;
            if (RST) begin
                t0[k] = -1;
                ih[k] = it[k];
                wh[k] = wt[k];
                la[k] = 0; lb[k] = 0; lt[k] = 0; ls[k] = 0;
                chk(tg(k, "WR_ADDR_A in reset"), wa[k], 0);
                chk(tg(k, "WR_ADDR_B in reset"), wb[k], 0);
            end
            rel = cyc - t0[k];
            ei = int'(t0[k] >= 0 && rel >= 1 && rel <= t && (rel - 1) % l < n / 2);
            ew = int'(t0[k] >= 0 && rel > pl && rel - pl <= t && (rel - pl - 1) % l < n / 2);
            ed = int'(t0[k] >= 0 && rel == t + 1);
            eb = int'(t0[k] >= 0 && rel >= 1 && rel <= t + 1);
            chk(tg(k, "ISSUE"), iss[k], ei);
            chk(tg(k, "WR_EN"), wen[k], ew);
            chk(tg(k, "DONE"), dn[k], ed);
            chk(tg(k, "BUSY"), bsy[k], eb);
            if (ei == 1 && iss[k] == 1) begin
                x = ih[k] % 64;
                ih[k]++;
                chk(tg(k, "ADDR_A"), a[k], qa[k][x]);
                chk(tg(k, "ADDR_B"), b[k], qb[k][x]);
                chk(tg(k, "TW_IDX"), tw[k], qt[k][x]);
                chk(tg(k, "STAGE"), st[k], qs[k][x]);
                la[k] = qa[k][x]; lb[k] = qb[k][x]; lt[k] = qt[k][x]; ls[k] = qs[k][x];
                wqa[k][wt[k] % 64] = qa[k][x];
                wqb[k][wt[k] % 64] = qb[k][x];
                wt[k]++;
            end else if (iss[k] == 0) begin
                chk(tg(k, "ADDR_A hold"), a[k], la[k]);
                chk(tg(k, "ADDR_B hold"), b[k], lb[k]);
                chk(tg(k, "TW_IDX hold"), tw[k], lt[k]);
                chk(tg(k, "STAGE hold"), st[k], ls[k]);
            end
            if (ew == 1 && wen[k] == 1) begin
                x = wh[k] % 64;
                wh[k]++;
                chk(tg(k, "WR_ADDR_A"), wa[k], wqa[k][x]);
                chk(tg(k, "WR_ADDR_B"), wb[k], wqb[k][x]);
            end
            if (!RST && start[k] && (t0[k] < 0 || rel >= t + 2)) begin
                t0[k] = cyc;
                for (int s = 0; s < lg; s++)
                    for (int j = 0; j < n / 2; j++) begin
                        span = n >> (s + 1);
                        x = it[k] % 64;
                        qa[k][x] = (j / span) * 2 * span + j % span;
                        qb[k][x] = qa[k][x] + span;
                        qt[k][x] = ((j % span) << s) % (n / 2);
                        qs[k][x] = s;
                        it[k]++;
                    end
            end
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        go(3);
        RST = 1'b0;
        go(2);
        start = 2'b11;
        go(1);
        start = 2'b00;
        go(2);
        start = 2'b11;
        go(1);
        start = 2'b00;
        go(6);
        start = 2'b11;
        go(1);
        start = 2'b00;
        go(14);
        start = 2'b11;
        go(2);
        start = 2'b00;
        go(30);
        start = 2'b11;
        go(1);
        start = 2'b00;
        go(10);
        RST = 1'b1;
        go(2);
        RST = 1'b0;
        go(2);
        start = 2'b11;
        go(1);
        start = 2'b00;
        go(45);
        for (int k = 0; k < 2; k++) begin
            chk(tg(k, "issue queue drained"), it[k] - ih[k], 0);
            chk(tg(k, "write-back queue drained"), wt[k] - wh[k], 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_r2_sched.md
Name: fft_r2_sched

Overview:
- Sequencer for the in-place radix-2 FFT datapath: drives one shared floating-point butterfly (24-bit mantissa, 8-bit exponent, sign pipeline) through all stages of an N = 2^LOG2N point transform.
- Generates operand read addresses, twiddle index and stage number per butterfly.
- Produces delayed write-back strobes/addresses aligned to the butterfly pipeline latency.
- Inserts drain gaps between stages so no read overtakes a pending write.

Parameters:
LOG2N, 3, log2 of transform size; legal range 2..15.
PIPE_LAT, 4, cycles from a butterfly issue to its write-back cycle; must be >= 1.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST  input  1  asynchronous active-high reset.
START  input  1  request a transform; sampled only in IDLE.
BUSY  output  1  high whenever the state is not IDLE.
DONE  output  1  one-cycle pulse when the transform completes.
ISSUE  output  1  butterfly operands valid this cycle.
ADDR_A  output  LOG2N  upper-leg read address.
ADDR_B  output  LOG2N  lower-leg read address.
TW_IDX  output  LOG2N-1  twiddle ROM index.
STAGE  output  4  current stage, 0..LOG2N-1.
WR_EN  output  1  write-back strobe: ISSUE delayed PIPE_LAT cycles.
WR_ADDR_A  output  LOG2N  ADDR_A delayed PIPE_LAT cycles.
WR_ADDR_B  output  LOG2N  ADDR_B delayed PIPE_LAT cycles.

Behaviour:
- Reset (async, any time, including mid-transform):
  - state IDLE; all outputs 0; stage, butterfly and drain counters 0.
  - write-back delay line cleared, so in-flight write-backs are suppressed.
- All outputs are registered.
- FSM:
  - IDLE: START=1 -> ISSUE with stage=0, j=0.
  - ISSUE: one butterfly per cycle, j = 0..N/2-1. After j = N/2-1 -> DRAIN, drain count = 0.
  - DRAIN: lasts exactly PIPE_LAT cycles. Then either stage+1 and ISSUE with j=0, or, if stage = LOG2N-1, go to FIN.
  - FIN: DONE=1 for one cycle -> IDLE.
- START is ignored in ISSUE, DRAIN and FIN. START held high continuously restarts a transform on the first IDLE cycle after FIN.
- Addressing for stage s and butterfly j:
  - span = N >> (s+1); pos = j & (span-1); grp = j >> (LOG2N-1-s).
  - ADDR_A = grp*2*span + pos, i.e. j with a 0 inserted at bit position LOG2N-1-s.
  - ADDR_B = ADDR_A + span.
  - TW_IDX = pos << s, truncated to LOG2N-1 bits.
- ADDR_A, ADDR_B, TW_IDX and STAGE are valid only while ISSUE=1. They hold their last value otherwise.
- Write-back path: PIPE_LAT-deep shift register of {ISSUE, ADDR_A, ADDR_B}. It runs continuously in every state, so the final stage's write-backs complete during the final DRAIN.
- Hazard rule: the first read of stage s+1 occurs one cycle after the last WR_EN of stage s. Memory writes commit at the clock edge ending the WR_EN cycle.
- Timing, with START accepted in cycle 0:
  - stage s issues in cycles 1 + s*(N/2+PIPE_LAT) .. that + N/2 - 1.
  - DONE in cycle 1 + LOG2N*(N/2+PIPE_LAT). For the defaults this is cycle 25.
- BUSY rises in cycle 1 and falls in the cycle after DONE.

Test Plan:
- Defaults; reset, then START pulse at cycle 0 -> stage 0 ISSUE cycles 1..4:
  - (A,B,TW) = (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - ISSUE low in cycles 5..8.
- Same run, later stages:
  - stage 1, cycles 9..12: (0,2,0), (1,3,2), (4,6,0), (5,7,2).
  - stage 2, cycles 17..20: (0,1,0), (2,3,0), (4,5,0), (6,7,0).
  - DONE only in cycle 25; BUSY high in cycles 1..25.
- Write-back alignment -> WR_EN high exactly in cycles 5..8, 13..16 and 21..24. WR_ADDR_A/B equal the addresses issued 4 cycles earlier. No WR_EN overlaps an ISSUE cycle of the following stage.
- START pulses at cycles 3, 10 and 25 during a run -> ignored. Second transform begins only after a fresh START in IDLE; START held high restarts at cycle 26 with first ISSUE in cycle 27.
- Assert RST in cycle 11 (mid stage 1) -> all outputs 0 immediately and no WR_EN afterwards. After release, a new START replays the stage 0 sequence from (0,4,0).
- LOG2N=4, PIPE_LAT=1 -> stage 3 pairs (2k, 2k+1) with TW=0. DONE in cycle 1 + 4*(8+1) = 37.
